// File: rtl/rs_opnd_trk_pkg.sv
// Shared types and default sizes for the reservation-station operand tracker.
package rs_defs;

  localparam int NUM_SRC_DEF = 2;
  localparam int NUM_WB_DEF  = 2;
  localparam int DATA_W_DEF  = 64;
  localparam int ROBID_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SRC = 2'd1,
    READY    = 2'd2
  } t_rs_opnd_fsm;

  typedef struct packed {
    logic                   from_rob;
    logic [ROBID_W_DEF-1:0] robid;
  } t_rs_src_descr;

endpackage

// File: rtl/rs_opnd_trk_if.sv
// Bundle of dispatch, ROB writeback and picker signals seen by one RS entry.
interface rs_opnd_trk_if
  import rs_defs::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_WB  = NUM_WB_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROBID_W = ROBID_W_DEF
);
  // No backpressure: alloc, wb and issue are single-cycle pulses qualified only by
  // their own enable bit; the entry reports occupancy on valid and eligibility on
  // ready_rs1, both straight from flops.
  logic                        alloc_rs0;
  logic [ROBID_W-1:0]          alloc_robid_rs0;
  logic [NUM_SRC-1:0]          alloc_from_rob_rs0;
  logic [NUM_SRC*ROBID_W-1:0]  alloc_src_robid_rs0;
  logic [NUM_SRC*DATA_W-1:0]   regrd_data_rs0;
  logic [NUM_WB-1:0]           wb_valid_rb0;
  logic [NUM_WB*ROBID_W-1:0]   wb_robid_rb0;
  logic [NUM_WB*DATA_W-1:0]    wb_value_rb0;
  logic                        flush;
  logic                        issue_rs1;
  logic                        valid;
  logic                        ready_rs1;
  logic [NUM_SRC-1:0]          src_rdy;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [ROBID_W-1:0]          e_robid;
  t_rs_opnd_fsm                state;

  modport master (
    output alloc_rs0, alloc_robid_rs0, alloc_from_rob_rs0, alloc_src_robid_rs0,
           regrd_data_rs0, wb_valid_rb0, wb_robid_rb0, wb_value_rb0, flush, issue_rs1,
    input  valid, ready_rs1, src_rdy, src_data, e_robid, state
  );

  modport slave (
    input  alloc_rs0, alloc_robid_rs0, alloc_from_rob_rs0, alloc_src_robid_rs0,
           regrd_data_rs0, wb_valid_rb0, wb_robid_rb0, wb_value_rb0, flush, issue_rs1,
    output valid, ready_rs1, src_rdy, src_data, e_robid, state
  );

endinterface

// File: rtl/rs_opnd_trk_src_slot.sv
// One source operand: ready/data/producer flops, writeback snoop and alloc-cycle bypass.
module rs_src_slot
  import rs_defs::*;
#(
  parameter int NUM_WB  = NUM_WB_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROBID_W = ROBID_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc,
  input  logic                       kill,
  input  logic                       pending,
  input  logic                       from_rob,
  input  logic [ROBID_W-1:0]         alloc_robid,
  input  logic [DATA_W-1:0]          regrd_data,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROBID_W-1:0]  wb_robid,
  input  logic [NUM_WB*DATA_W-1:0]   wb_value,
  output logic                       rdy,
  output logic                       rdy_nxt,
  output logic [DATA_W-1:0]          data
);

  t_rs_src_descr       descr_q, descr_d;
  logic [ROBID_W-1:0]  key;
  logic [NUM_WB-1:0]   match;
  logic                hit;
  logic [DATA_W-1:0]   hit_val;
  logic [DATA_W-1:0]   data_d;
  logic                snooping;

  // During alloc the incoming producer id is compared so a same-cycle wb is caught.
  assign key      = alloc ? alloc_robid : descr_q.robid;
  assign snooping = !kill && ((alloc && from_rob) || (pending && !rdy));

  always_comb begin
    match = '0;
    for (int j = 0; j < NUM_WB; j++)
      match[j] = wb_valid[j] && (wb_robid[j*ROBID_W +: ROBID_W] == key);
  end

  // Walk downwards so the lowest matching port is the last (winning) assignment.
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int j = NUM_WB - 1; j >= 0; j--) begin
      if (match[j]) begin
        hit     = 1'b1;
        hit_val = wb_value[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdy_nxt = rdy;
    data_d  = data;
    descr_d = descr_q;
    if (kill) begin
      rdy_nxt = 1'b0;
    end else if (alloc) begin
      descr_d.from_rob = from_rob;
      descr_d.robid    = alloc_robid;
      if (!from_rob) begin
        rdy_nxt = 1'b1;
        data_d  = regrd_data;
      end else if (hit) begin
        rdy_nxt = 1'b1;
        data_d  = hit_val;
      end else begin
        rdy_nxt = 1'b0;
      end
    end else if (pending && !rdy && hit) begin
      rdy_nxt = 1'b1;
      data_d  = hit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy     <= 1'b0;
      data    <= '0;
      descr_q <= '0;
    end else begin
      rdy     <= rdy_nxt;
      data    <= data_d;
      descr_q <= descr_d;
    end
  end

  a_single_wb_match : assert property (@(posedge clk) disable iff (reset)
    snooping |-> ($countones(match) <= 1));

endmodule

// File: rtl/rs_opnd_trk.sv
// RS entry: lifecycle FSM, uop ROB id, and per-source operand slots.
module rs_opnd_trk
  import rs_defs::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_WB  = NUM_WB_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROBID_W = ROBID_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  rs_opnd_trk_if.slave  bus
);

  t_rs_opnd_fsm               state_q, state_d;
  logic [ROBID_W-1:0]         e_robid_q;
  logic [NUM_SRC-1:0]         src_rdy_q, src_rdy_d;
  logic [NUM_SRC*DATA_W-1:0]  src_data_w;
  logic                       alloc_go, issue_go, kill;

  assign alloc_go = bus.alloc_rs0 && (state_q == IDLE) && !bus.flush;
  assign issue_go = bus.issue_rs1 && (state_q == READY) && !bus.flush;
  assign kill     = bus.flush || issue_go;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    rs_src_slot #(
      .NUM_WB  (NUM_WB),
      .DATA_W  (DATA_W),
      .ROBID_W (ROBID_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .alloc       (alloc_go),
      .kill        (kill),
      .pending     (state_q == WAIT_SRC),
      .from_rob    (bus.alloc_from_rob_rs0[i]),
      .alloc_robid (bus.alloc_src_robid_rs0[i*ROBID_W +: ROBID_W]),
      .regrd_data  (bus.regrd_data_rs0[i*DATA_W +: DATA_W]),
      .wb_valid    (bus.wb_valid_rb0),
      .wb_robid    (bus.wb_robid_rb0),
      .wb_value    (bus.wb_value_rb0),
      .rdy         (src_rdy_q[i]),
      .rdy_nxt     (src_rdy_d[i]),
      .data        (src_data_w[i*DATA_W +: DATA_W])
    );
  end

  // The READY decision uses the slots' next-ready so ready_rs1 itself stays a flop.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (issue_go) begin
      state_d = IDLE;
    end else if (alloc_go) begin
      state_d = (&src_rdy_d) ? READY : WAIT_SRC;
    end else if ((state_q == WAIT_SRC) && (&src_rdy_d)) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      e_robid_q <= '0;
    end else begin
      state_q <= state_d;
      if (alloc_go) e_robid_q <= bus.alloc_robid_rs0;
    end
  end

  assign bus.valid     = (state_q != IDLE);
  assign bus.ready_rs1 = (state_q == READY);
  assign bus.src_rdy   = src_rdy_q;
  assign bus.src_data  = src_data_w;
  assign bus.e_robid   = e_robid_q;
  assign bus.state     = state_q;

  a_alloc_only_idle : assert property (@(posedge clk) disable iff (reset)
    bus.alloc_rs0 |-> (state_q == IDLE));
  a_issue_only_ready : assert property (@(posedge clk) disable iff (reset)
    bus.issue_rs1 |-> (state_q == READY));

endmodule
